// File: rtl/spi_pkg.sv
// spi_pkg: constants shared between the SPI master and slave, plus the
// master FSM state type.
package spi_pkg;

    localparam int SPI_FRAME_BITS = 32;
    localparam int SPI_DIV_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_master_tx_sck_gen.sv
// sck_gen: divides clk by CLK_DIV into sck half-periods while enabled and
// flags each sck edge with a one-cycle strobe; sck is parked low when disabled.
module sck_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic riseStb,
    output logic fallStb,
    output logic sck
);

    localparam logic [SPI_DIV_W-1:0] DIV_LAST = SPI_DIV_W'(CLK_DIV - 1);

    logic [SPI_DIV_W-1:0] r_div_cnt;
    logic                 r_sck;
    logic                 w_edge;

    assign w_edge  = enable && (r_div_cnt == DIV_LAST);
    assign riseStb = w_edge && !r_sck;
    assign fallStb = w_edge && r_sck;
    assign sck     = r_sck;

    // Half-period counter and sck level; disabling restarts the next frame from sck low.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_div_cnt <= '0;
            r_sck     <= 1'b0;
        end else if (w_edge) begin
            r_div_cnt <= '0;
            r_sck     <= ~r_sck;
        end else begin
            r_div_cnt <= r_div_cnt + SPI_DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_tx.sv
// spi_master_tx: mode-0 SPI master. Sends one N_BITS word MSB-first on sdo
// and captures the reply from sdi on every sck rising edge.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int N_BITS  = SPI_FRAME_BITS,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_BITS-1:0] txData,
    output logic [N_BITS-1:0] rxData,
    output logic              busy,
    output logic              done,
    output logic              sck,
    output logic              sdo,
    input  logic              sdi,
    output logic              csN
);

    localparam int                    CNT_W    = $clog2(N_BITS + 1);
    localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(N_BITS - 1);
    localparam logic [SPI_DIV_W-1:0]  DIV_LAST = SPI_DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("spi_master_tx: CLK_DIV must be in 1..255");
    end
    if (N_BITS < 2) begin : g_bad_n_bits
        $error("spi_master_tx: N_BITS must be at least 2");
    end

    spi_state_t           r_state;
    spi_state_t           w_state_nxt;
    logic [N_BITS-1:0]    r_tx_sh;
    logic [N_BITS-1:0]    w_tx_sh_nxt;
    logic [N_BITS-1:0]    r_rx_sh;
    logic [N_BITS-1:0]    w_rx_sh_nxt;
    logic [N_BITS-1:0]    r_rx_data;
    logic [N_BITS-1:0]    w_rx_data_nxt;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [CNT_W-1:0]     w_bit_cnt_nxt;
    logic [SPI_DIV_W-1:0] r_trail_cnt;
    logic [SPI_DIV_W-1:0] w_trail_cnt_nxt;
    logic                 r_csn;
    logic                 w_csn_nxt;
    logic                 r_sdo;
    logic                 w_sdo_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_done;
    logic                 w_done_nxt;

    logic                 w_gen_en;
    logic                 w_rise_stb;
    logic                 w_fall_stb;
    logic                 w_sck;

    // The divider only runs while sck pulses are due; TRAIL is timed locally so sck stays low.
    assign w_gen_en = (r_state == LEAD) || (r_state == SHIFT);

    sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk     (clk),
        .reset   (reset),
        .enable  (w_gen_en),
        .riseStb (w_rise_stb),
        .fallStb (w_fall_stb),
        .sck     (w_sck)
    );

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_tx_sh_nxt     = r_tx_sh;
        w_rx_sh_nxt     = r_rx_sh;
        w_rx_data_nxt   = r_rx_data;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_trail_cnt_nxt = r_trail_cnt;
        w_csn_nxt       = r_csn;
        w_sdo_nxt       = r_sdo;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt     = LEAD;
                    w_tx_sh_nxt     = txData;
                    w_sdo_nxt       = txData[N_BITS-1];
                    w_rx_sh_nxt     = '0;
                    w_bit_cnt_nxt   = '0;
                    w_trail_cnt_nxt = '0;
                    w_csn_nxt       = 1'b0;
                    w_busy_nxt      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end

            LEAD: begin
                // The first strobe after the lead-in is always the rising edge of bit 0.
                if (w_rise_stb) begin
                    w_rx_sh_nxt = {r_rx_sh[N_BITS-2:0], sdi};
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = LEAD;
                end
            end

            SHIFT: begin
                if (w_rise_stb) begin
                    w_rx_sh_nxt = {r_rx_sh[N_BITS-2:0], sdi};
                end else if (w_fall_stb) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt     = TRAIL;
                        w_trail_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                        w_tx_sh_nxt   = {r_tx_sh[N_BITS-2:0], 1'b0};
                        w_sdo_nxt     = r_tx_sh[N_BITS-2];
                    end
                end else begin
                    w_state_nxt = SHIFT;
                end
            end

            TRAIL: begin
                if (r_trail_cnt == DIV_LAST) begin
                    w_state_nxt   = IDLE;
                    w_csn_nxt     = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_rx_data_nxt = r_rx_sh;
                end else begin
                    w_trail_cnt_nxt = r_trail_cnt + SPI_DIV_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_csn_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tx_sh     <= '0;
            r_rx_sh     <= '0;
            r_rx_data   <= '0;
            r_bit_cnt   <= '0;
            r_trail_cnt <= '0;
            r_csn       <= 1'b1;
            r_sdo       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tx_sh     <= w_tx_sh_nxt;
            r_rx_sh     <= w_rx_sh_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_trail_cnt <= w_trail_cnt_nxt;
            r_csn       <= w_csn_nxt;
            r_sdo       <= w_sdo_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign rxData = r_rx_data;
    assign busy   = r_busy;
    assign done   = r_done;
    assign sck    = w_sck;
    assign sdo    = r_sdo;
    assign csN    = r_csn;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: two instances (CLK_DIV 4 and 1) checked every cycle
// against a frame-timing model, plus literal expectations for key events.
module tb_spi_master_tx;

    localparam int N = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         start_i  [2];
    logic [N-1:0] tx_i     [2];
    logic [1:0]   sdi_mode [2];
    logic [N-1:0] rx_o     [2];
    logic         busy_o   [2];
    logic         done_o   [2];
    logic         sck_o    [2];
    logic         sdo_o    [2];
    logic         csn_o    [2];
    logic         chk_en = 1'b0;
    logic         mon_clr = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // sck is high during odd half-period phases of the shifting window.
    function automatic logic f_sck(input int t, input int d);
        int p = t / d;
        return (p % 2 == 1) && (p < 2 * N);
    endfunction

    // Bit j of the frame (MSB first) is on sdo from fall j-1 until fall j; the last bit holds.
    function automatic logic f_sdo(input logic [N-1:0] tx, input int t, input int d);
        int j = t / d / 2;
        if (j > N - 1) j = N - 1;
        return tx[N - 1 - j];
    endfunction

    // Bench-side slave: loads d, shifts out MSB-first on falls, captures sdo on rises.
    logic [N-1:0] sl_d = '0;
    logic [N-1:0] sl_sh = '0;
    logic [N-1:0] sl_q = '0;
    logic         sl_load = 1'b0;
    logic         sl_sck_q = 1'b0;

    always @(posedge clk) begin
        sl_sck_q <= sck_o[0];
        if (sl_load) begin
            sl_sh <= sl_d;
            sl_q  <= '0;
        end else begin
            if (sl_sck_q && !sck_o[0]) sl_sh <= {sl_sh[N-2:0], 1'b0};
            if (!sl_sck_q && sck_o[0]) sl_q <= {sl_q[N-2:0], sdo_o[0]};
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int D = (g == 0) ? 4 : 1;

        logic sdi_rnd = 1'b0;
        logic w_sdi;
        always @(negedge clk) sdi_rnd <= 1'($urandom_range(0, 1));
        assign w_sdi = (sdi_mode[g] == 2'd1) ? sdo_o[g] :
                       (sdi_mode[g] == 2'd2) ? sl_sh[N-1] : sdi_rnd;

        spi_master_tx #(.N_BITS(N), .CLK_DIV(D)) u_dut (
            .clk    (clk),
            .reset  (reset),
            .start  (start_i[g]),
            .txData (tx_i[g]),
            .rxData (rx_o[g]),
            .busy   (busy_o[g]),
            .done   (done_o[g]),
            .sck    (sck_o[g]),
            .sdo    (sdo_o[g]),
            .sdi    (w_sdi),
            .csN    (csn_o[g])
        );

        // Model: m_t counts edges since the accepting edge; frame lasts (2N+1)*D edges.
        bit           m_act = 1'b0;
        bit           m_done = 1'b0;
        int           m_t = 0;
        int           m_acc = 0;
        logic [N-1:0] m_tx = '0;
        logic [N-1:0] m_sh = '0;
        logic [N-1:0] m_rx = '0;

        always @(posedge clk) begin
            if (reset) begin
                m_act  <= 1'b0;
                m_done <= 1'b0;
                m_rx   <= '0;
            end else if (!m_act) begin
                m_done <= 1'b0;
                if (start_i[g]) begin
                    m_act <= 1'b1;
                    m_t   <= 0;
                    m_tx  <= tx_i[g];
                    m_sh  <= '0;
                    m_acc <= cyc;
                end
            end else begin
                m_t <= m_t + 1;
                if (((m_t + 1) % D == 0) && (((m_t + 1) / D) % 2 == 1) && ((m_t + 1) / D < 2 * N))
                    m_sh <= {m_sh[N-2:0], (sdi_mode[g] == 2'd1) ? f_sdo(m_tx, m_t, D) : w_sdi};
                if (m_t + 1 == (2 * N + 1) * D) begin
                    m_act  <= 1'b0;
                    m_done <= 1'b1;
                    m_rx   <= m_sh;
                end
            end
        end

        int   n_rise = 0;
        int   n_done = 0;
        int   first_rise = -1;
        int   done_rel = -1;
        int   done_cyc [4];
        logic prev_sck = 1'b0;

        // Per-cycle comparison against the model plus event monitors.
        always @(negedge clk) begin
            prev_sck <= sck_o[g];
            if (mon_clr) begin
                n_rise     <= 0;
                n_done     <= 0;
                first_rise <= -1;
                done_rel   <= -1;
            end else if (chk_en) begin
                if (!prev_sck && sck_o[g]) begin
                    n_rise <= n_rise + 1;
                    if (first_rise < 0) first_rise <= cyc - m_acc;
                end
                if (done_o[g]) begin
                    if (n_done < 4) done_cyc[n_done] <= cyc;
                    n_done   <= n_done + 1;
                    done_rel <= cyc - m_acc;
                end
            end
            if (chk_en) begin
                check($sformatf("csN[%0d]", g), N'(csn_o[g]), N'(!m_act));
                check($sformatf("busy[%0d]", g), N'(busy_o[g]), N'(m_act));
                check($sformatf("done[%0d]", g), N'(done_o[g]), N'(m_done && !m_act));
                check($sformatf("sck[%0d]", g), N'(sck_o[g]), N'(m_act && f_sck(m_t, D)));
                check($sformatf("rxData[%0d]", g), rx_o[g], m_rx);
                if (m_act) check($sformatf("sdo[%0d]", g), N'(sdo_o[g]), N'(f_sdo(m_tx, m_t, D)));
            end
        end
    end

    task automatic wait_done(input int g, input int budget, input string name);
        int k = 0;
        while (done_o[g] !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, N'(done_o[g]), N'(1));
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(posedge clk);
        @(posedge clk);
        mon_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start(input int g);
        start_i[g] = 1'b1;
        @(negedge clk);
        start_i[g] = 1'b0;
    endtask

    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] tx_b2b;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_i[i]  = 1'b0;
            tx_i[i]     = '0;
            sdi_mode[i] = 2'd0;
        end
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b0;
        clr_mon();

        // Idle after reset.
        repeat (100) @(negedge clk);
        check("idle_rx", rx_o[0], 32'h0000_0000);
        check("idle_csn", N'(csn_o[0]), 32'h0000_0001);
        check("idle_sck", N'(sck_o[0]), 32'h0000_0000);

        // Loopback frame with start re-pulsed mid-frame and txData changed after acceptance.
        sdi_mode[0] = 2'd1;
        tx_i[0]     = 32'hA5C3_0F81;
        pulse_start(0);
        tx_i[0] = 32'hFFFF_0000;
        repeat (48) @(negedge clk);
        pulse_start(0);
        repeat (149) @(negedge clk);
        pulse_start(0);
        wait_done(0, 300, "loop_done");
        check("loop_rx", rx_o[0], 32'hA5C3_0F81);
        @(negedge clk);
        check("loop_rises", N'(g_inst[0].n_rise), 32'd32);
        check("loop_first_rise", N'(g_inst[0].first_rise), 32'd5);
        check("loop_done_cycle", N'(g_inst[0].done_rel), 32'd261);
        repeat (5) @(negedge clk);
        check("loop_one_done", N'(g_inst[0].n_done), 32'd1);

        // Frame against the bench-side slave.
        sdi_mode[0] = 2'd2;
        sl_d        = 32'h1234_5678;
        sl_load     = 1'b1;
        @(negedge clk);
        sl_load = 1'b0;
        tx_i[0] = 32'h0000_00C8;
        pulse_start(0);
        wait_done(0, 400, "slave_done");
        check("slave_rx", rx_o[0], 32'h1234_5678);
        @(negedge clk);
        check("slave_q", sl_q, 32'h0000_00C8);

        // Randomized frames with random sdi, random gaps and back-to-back chaining.
        sdi_mode[0] = 2'd0;
        for (int f = 0; f < 6; f++) begin
            tx_i[0]    = $urandom;
            start_i[0] = 1'b1;
            @(negedge clk);
            start_i[0] = 1'($urandom_range(0, 1));
            wait_done(0, 400, "rand_done");
            if (!start_i[0]) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        start_i[0] = 1'b0;
        repeat (5) @(negedge clk);

        // CLK_DIV=1 with start held high for three frames.
        sdi_mode[1] = 2'd1;
        tx_b2b      = $urandom;
        tx_i[1]     = tx_b2b;
        clr_mon();
        start_i[1] = 1'b1;
        wait_done(1, 100, "b2b_done0");
        @(negedge clk);
        wait_done(1, 100, "b2b_done1");
        @(negedge clk);
        wait_done(1, 100, "b2b_done2");
        start_i[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_rises", N'(g_inst[1].n_rise), 32'd96);
        check("b2b_dones", N'(g_inst[1].n_done), 32'd3);
        check("b2b_gap01", N'(g_inst[1].done_cyc[1] - g_inst[1].done_cyc[0]), 32'd66);
        check("b2b_gap12", N'(g_inst[1].done_cyc[2] - g_inst[1].done_cyc[1]), 32'd66);
        check("b2b_rx", rx_o[1], tx_b2b);

        // Reset in the middle of a frame, then a clean frame.
        sdi_mode[0] = 2'd1;
        tx_i[0]     = $urandom;
        clr_mon();
        pulse_start(0);
        repeat (118) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_sck", N'(sck_o[0]), 32'd0);
        check("rst_csn", N'(csn_o[0]), 32'd1);
        check("rst_busy", N'(busy_o[0]), 32'd0);
        check("rst_rx", rx_o[0], 32'h0000_0000);
        check("rst_done", N'(done_o[0]), 32'd0);
        repeat (10) @(negedge clk);
        check("rst_no_done", N'(g_inst[0].n_done), 32'd0);
        clr_mon();
        tx_i[0] = 32'h5A5A_F00F;
        pulse_start(0);
        wait_done(0, 400, "post_rst_done");
        check("post_rst_rx", rx_o[0], 32'h5A5A_F00F);
        @(negedge clk);
        check("post_rst_rises", N'(g_inst[0].n_rise), 32'd32);
        check("post_rst_dones", N'(g_inst[0].n_done), 32'd1);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
